// File: rtl/data_sram_like_bridge_pkg.sv
// Shared types for the data-side sram-like bridge.
// Holds FSM state encodings and sram-like size codes.
package data_sram_like_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/data_sram_like_bridge_wen_size_enc.sv
// Maps byte write-enables (or read size) to the sram-like size.
// Irregular enable patterns fall back to a full word.
module wen_size_enc
   import data_sram_like_bridge_pkg::*;
(
   input  logic [3:0] mem_wen,
   input  logic [1:0] mem_rsize,
   output logic [1:0] data_size
);

   // writes encode size from the enable mask, reads pass rsize through
   always_comb begin
      data_size = SIZE_WORD;
      case (mem_wen)
         4'b0000: data_size = mem_rsize;
         4'b0001,
         4'b0010,
         4'b0100,
         4'b1000: data_size = SIZE_BYTE;
         4'b0011,
         4'b1100: data_size = SIZE_HALF;
         default: data_size = SIZE_WORD;
      endcase
   end

endmodule

// File: rtl/data_sram_like_bridge.sv
// MEM-stage bridge: one memory access becomes one sram-like transaction.
// Stalls the pipe until done and holds the read word until release.
module data_sram_like_bridge
   import data_sram_like_bridge_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en,
   input  logic [3:0]  mem_wen,
   input  logic [1:0]  mem_rsize,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        pipe_stall,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   output logic        stall_req,
   output logic [31:0] rdata_out
);

   state_t      state;
   logic        wr_q;
   logic        wr;
   logic        issue;
   logic        fin;
   logic        rd_txn;
   logic [31:0] rdata_q;

   assign wr         = |mem_wen;
   assign issue      = (state == ST_IDLE) && mem_en;
   assign data_req   = issue || (state == ST_REQ);
   assign stall_req  = issue || (state == ST_REQ) || (state == ST_WAIT);
   assign data_wr    = wr;
   assign data_addr  = mem_addr;
   assign data_wdata = mem_wdata;
   assign rdata_out  = rdata_q;

   // direction of the in-flight transaction, latched at issue
   assign rd_txn = (state == ST_IDLE) ? !wr : !wr_q;

   wen_size_enc u_size (
      .mem_wen   (mem_wen),
      .mem_rsize (mem_rsize),
      .data_size (data_size)
   );

   // transaction completes this cycle; stray data_ok is ignored
   always_comb begin
      fin = 1'b0;
      case (state)
         ST_IDLE: fin = mem_en && data_addr_ok && data_data_ok;
         ST_REQ:  fin = data_addr_ok && data_data_ok;
         ST_WAIT: fin = data_data_ok;
         default: fin = 1'b0;
      endcase
   end

   // request/wait/done sequencing, one transaction per instruction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         wr_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mem_en) begin
                  wr_q <= wr;
                  if (fin)
                     state <= ST_DONE;
                  else if (data_addr_ok)
                     state <= ST_WAIT;
                  else
                     state <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (fin)
                  state <= ST_DONE;
               else if (data_addr_ok)
                  state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (fin)
                  state <= ST_DONE;
            end
            ST_DONE: begin
               if (!pipe_stall)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // capture read data on completion of a read; writes leave it alone
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rdata_q <= 32'd0;
      else if (fin && rd_txn)
         rdata_q <= data_rdata;
   end

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Bench for data_sram_like_bridge: directed cases plus random traffic
// checked every cycle against a transaction-level model.
module tb_data_sram_like_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_en = 1'b0;
   logic [3:0]  mem_wen = 4'd0;
   logic [1:0]  mem_rsize = 2'd0;
   logic [31:0] mem_addr = 32'd0;
   logic [31:0] mem_wdata = 32'd0;
   logic        pipe_stall = 1'b0;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok = 1'b0;
   logic        data_data_ok = 1'b0;
   logic [31:0] data_rdata = 32'd0;
   logic        stall_req;
   logic [31:0] rdata_out;

   int total = 0;
   int bad = 0;

   // model: is a transaction in flight, has its address been taken,
   // is a finished access waiting for the pipe, and what it returned
   bit          m_busy = 0;
   bit          m_acc = 0;
   bit          m_hold = 0;
   bit          m_wr = 0;
   logic [31:0] m_rdata = 32'd0;
   bit          advanced = 0;
   int          n_txn = 0;

   data_sram_like_bridge dut (
      .clk          (clk),
      .rst          (rst),
      .mem_en       (mem_en),
      .mem_wen      (mem_wen),
      .mem_rsize    (mem_rsize),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .pipe_stall   (pipe_stall),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .stall_req    (stall_req),
      .rdata_out    (rdata_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] size_of(input logic [3:0] w,
                                          input logic [1:0] rs);
      if (w == 4'd0) return rs;
      if ($countones(w) == 1) return 2'd0;
      if (w == 4'b0011 || w == 4'b1100) return 2'd1;
      return 2'd2;
   endfunction

   function automatic bit issue_now();
      return !m_busy && !m_hold && mem_en;
   endfunction

   function automatic bit exp_req();
      return issue_now() || (m_busy && !m_acc);
   endfunction

   function automatic bit exp_stall();
      return issue_now() || m_busy;
   endfunction

   // model advance at each edge, asynchronous reset clears it
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_busy = 0;
            m_acc = 0;
            m_hold = 0;
            m_rdata = 32'd0;
            advanced = 1;
         end else begin
            bit live;
            bit w;
            bit done;
            advanced = !exp_stall() && !pipe_stall;
            live = issue_now() || m_busy;
            w = issue_now() ? (mem_wen != 4'd0) : m_wr;
            if (live) begin
               done = m_acc ? data_data_ok
                            : (data_addr_ok && data_data_ok);
               m_wr = w;
               if (done) begin
                  m_busy = 0;
                  m_acc = 0;
                  m_hold = 1;
                  n_txn++;
                  if (!w) m_rdata = data_rdata;
               end else begin
                  m_busy = 1;
                  if (data_addr_ok) m_acc = 1;
               end
            end else if (m_hold && !pipe_stall) begin
               m_hold = 0;
            end
         end
      end
   end

   // every-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("req", {31'd0, data_req}, {31'd0, exp_req()});
            chk("stall", {31'd0, stall_req}, {31'd0, exp_stall()});
            chk("wr", {31'd0, data_wr}, {31'd0, mem_wen != 4'd0});
            chk("size", {30'd0, data_size},
                {30'd0, size_of(mem_wen, mem_rsize)});
            chk("addr", data_addr, mem_addr);
            chk("wdata", data_wdata, mem_wdata);
            chk("rdata_out", rdata_out, m_rdata);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   logic [3:0] wen_tab [15] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4,
                                4'h8, 4'h3, 4'hC, 4'hF, 4'h5, 4'h6,
                                4'h7, 4'h9, 4'hE};

   task automatic new_instr();
      mem_en = ($urandom_range(0, 9) < 6);
      mem_wen = wen_tab[$urandom_range(0, 14)];
      mem_rsize = 2'($urandom_range(0, 2));
      mem_addr = $urandom;
      mem_wdata = $urandom;
   endtask

   initial begin
      int t0;
      // reset state, outputs follow inputs
      #3;
      mem_en = 1'b1;
      mem_wen = 4'b0011;
      #1;
      chk("rst_rdata", rdata_out, 32'd0);
      chk("rst_req", {31'd0, data_req}, 32'd1);
      chk("rst_stall", {31'd0, stall_req}, 32'd1);
      chk("rst_wr", {31'd0, data_wr}, 32'd1);
      mem_en = 1'b0;
      mem_wen = 4'd0;
      step();
      rst = 1'b0;
      step();

      // word read, addr_ok cycle 0, data_ok cycle 1
      mem_en = 1; mem_wen = 0; mem_rsize = 2; mem_addr = 32'h1000_0004;
      data_addr_ok = 1; data_data_ok = 0;
      at_neg();
      chk("wr_c0_req", {31'd0, data_req}, 32'd1);
      chk("wr_c0_size", {30'd0, data_size}, 32'd2);
      chk("wr_c0_wr", {31'd0, data_wr}, 32'd0);
      step();
      data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
      at_neg();
      chk("wr_c1_req", {31'd0, data_req}, 32'd0);
      chk("wr_c1_stall", {31'd0, stall_req}, 32'd1);
      step();
      data_data_ok = 0; data_rdata = 32'h0;
      at_neg();
      chk("wr_c2_stall", {31'd0, stall_req}, 32'd0);
      chk("wr_c2_rdata", rdata_out, 32'hDEAD_BEEF);
      step();
      mem_en = 0;

      // byte store, addr_ok withheld 3 cycles
      mem_en = 1; mem_wen = 4'b0100; mem_addr = 32'h2000_0006;
      mem_wdata = 32'h5A5A_5A5A;
      t0 = n_txn;
      for (int i = 0; i < 3; i++) begin
         at_neg();
         chk("bs_req_held", {31'd0, data_req}, 32'd1);
         step();
      end
      data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h1111_1111;
      at_neg();
      chk("bs_req_c3", {31'd0, data_req}, 32'd1);
      chk("bs_size", {30'd0, data_size}, 32'd0);
      chk("bs_wr", {31'd0, data_wr}, 32'd1);
      step();
      data_addr_ok = 0; data_data_ok = 0;
      at_neg();
      chk("bs_done_stall", {31'd0, stall_req}, 32'd0);
      chk("bs_rdata_kept", rdata_out, 32'hDEAD_BEEF);
      chk("bs_one_txn", n_txn - t0, 32'd1);
      step();
      mem_en = 0;

      // half read, best case, then held in DONE by pipe_stall
      mem_en = 1; mem_wen = 0; mem_rsize = 1; mem_addr = 32'h3000_0002;
      data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h1234_5678;
      pipe_stall = 1;
      at_neg();
      chk("hr_size", {30'd0, data_size}, 32'd1);
      step();
      data_rdata = 32'hFFFF_0000;
      for (int i = 0; i < 5; i++) begin
         at_neg();
         chk("hold_stall", {31'd0, stall_req}, 32'd0);
         chk("hold_req", {31'd0, data_req}, 32'd0);
         chk("hold_rdata", rdata_out, 32'h1234_5678);
         step();
      end
      pipe_stall = 0; data_addr_ok = 0; data_data_ok = 0;
      step();
      // back-to-back: next access requests in the IDLE cycle
      mem_rsize = 2; mem_addr = 32'h3000_0008;
      data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'hCAFE_F00D;
      at_neg();
      chk("b2b_req", {31'd0, data_req}, 32'd1);
      step();
      data_addr_ok = 0; data_data_ok = 0;
      at_neg();
      chk("b2b_rdata", rdata_out, 32'hCAFE_F00D);
      step();
      mem_en = 0;

      // stray data_ok while idle
      data_data_ok = 1; data_rdata = 32'hFFFF_FFFF;
      at_neg();
      chk("stray_req", {31'd0, data_req}, 32'd0);
      step();
      data_data_ok = 0;
      at_neg();
      chk("stray_rdata", rdata_out, 32'hCAFE_F00D);
      step();

      // reset while waiting for data_ok; mem_en drop has no effect
      mem_en = 1; mem_wen = 0; data_addr_ok = 1;
      step();
      data_addr_ok = 0; mem_en = 0;
      at_neg();
      chk("wait_stall", {31'd0, stall_req}, 32'd1);
      step();
      #1 rst = 1;
      #1;
      chk("arst_req", {31'd0, data_req}, 32'd0);
      chk("arst_stall", {31'd0, stall_req}, 32'd0);
      chk("arst_rdata", rdata_out, 32'd0);
      step();
      rst = 0;
      step();

      // random traffic
      new_instr();
      for (int c = 0; c < 3000; c++) begin
         pipe_stall = ($urandom_range(0, 9) < 3);
         data_addr_ok = $urandom_range(0, 1);
         data_data_ok = $urandom_range(0, 1);
         data_rdata = $urandom;
         if ((m_busy || m_hold) && $urandom_range(0, 7) == 0)
            mem_en = 0;
         step();
         if (advanced) new_instr();
      end
      chk("txn_seen", {31'd0, n_txn > 100}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
